eth_arp_hdr_parser: RTL and testbench

ETH_ARP_HDR_PARSER -- requirements
Module: eth_arp_hdr_parser

---
 rtl/eth_arp_hdr_parser_pkg.sv | 24 ++
 rtl/eth_arp_hdr_parser.sv | 190 +++++++++++++++++++
 tb/tb_eth_arp_hdr_parser.sv | 370 +++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/eth_arp_hdr_parser_pkg.sv
// Shared constants, FSM encoding and helpers for the Ethernet/ARP header parser.
package eth_arp_hdr_parser_pkg;

   localparam logic [15:0] ETHERTYPE_ARP  = 16'h0806;
   localparam logic [15:0] ARP_OP_REQUEST = 16'h0001;
   localparam logic [15:0] ARP_OP_REPLY   = 16'h0002;

   typedef enum logic [2:0] {
      ST_WORD0    = 3'd0,
      ST_WORD1    = 3'd1,
      ST_WORD2    = 3'd2,
      ST_WORD3    = 3'd3,
      ST_WAIT_EOP = 3'd4
   } hdr_state_e;

   function automatic logic [15:0] sat_inc16(input logic [15:0] v);
      if (v == 16'hFFFF) begin
         return v;
      end else begin
         return v + 16'd1;
      end
   endfunction

endpackage

// File: rtl/eth_arp_hdr_parser.sv
// Passive AXI-Stream tap extracting Ethernet/ARP header fields for the learning CAM lookup.
// Optional ARP_SPOOF_CHECK_EN adds spoof_flag (ARP sender MAC differs from Ethernet source MAC).
module eth_arp_hdr_parser
   import eth_arp_hdr_parser_pkg::*;
#(
   parameter int NUM_OUTPUT_QUEUES    = 8,
   parameter int SRC_PORT_POS         = 16,
   parameter int C_S_AXIS_TUSER_WIDTH = 128
) (
   input  logic                            clk,
   input  logic                            reset,
   input  logic [63:0]                     s_axis_tdata,
   input  logic [7:0]                      s_axis_tkeep,
   input  logic [C_S_AXIS_TUSER_WIDTH-1:0] s_axis_tuser,
   input  logic                            s_axis_tvalid,
   input  logic                            s_axis_tready,
   input  logic                            s_axis_tlast,
   output logic [47:0]                     dst_mac,
   output logic [47:0]                     src_mac,
   output logic [NUM_OUTPUT_QUEUES-1:0]    src_port,
   output logic [15:0]                     opcode,
   output logic [47:0]                     arp_sha,
   output logic                            arp_valid,
   output logic                            lookup_req,
`ifdef ARP_SPOOF_CHECK_EN
   output logic                            spoof_flag,
`endif
   output logic [15:0]                     runt_count
);

   logic                         beat_s;
   logic [47:0]                  src_full_s;
   logic [47:0]                  sha_full_s;
   logic [15:0]                  ethertype_s;
   logic                         unused_ok_s;

   hdr_state_e                   state_q;
   logic [47:0]                  dst_sh_q;
   logic [47:0]                  src_sh_q;
   logic [NUM_OUTPUT_QUEUES-1:0] port_sh_q;
   logic [15:0]                  op_sh_q;
   logic [15:0]                  sha_hi_sh_q;

   logic [47:0]                  dst_mac_q;
   logic [47:0]                  src_mac_q;
   logic [NUM_OUTPUT_QUEUES-1:0] src_port_q;
   logic [15:0]                  opcode_q;
   logic [47:0]                  arp_sha_q;
   logic                         arp_valid_q;
   logic                         lookup_req_q;
   logic [15:0]                  runt_count_q;
`ifdef ARP_SPOOF_CHECK_EN
   logic                         spoof_q;
`endif

   assign beat_s      = s_axis_tvalid & s_axis_tready;
   // Fields completed by the current beat are forwarded straight from tdata.
   assign src_full_s  = {src_sh_q[47:32], s_axis_tdata[63:32]};
   assign sha_full_s  = {sha_hi_sh_q, s_axis_tdata[63:32]};
   assign ethertype_s = s_axis_tdata[31:16];
   assign unused_ok_s = ^{s_axis_tkeep, s_axis_tuser};

   // Header walk: shadow captures per word, lookup outputs loaded when the header completes
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= ST_WORD0;
         dst_sh_q     <= 48'h0;
         src_sh_q     <= 48'h0;
         port_sh_q    <= '0;
         op_sh_q      <= 16'h0;
         sha_hi_sh_q  <= 16'h0;
         dst_mac_q    <= 48'h0;
         src_mac_q    <= 48'h0;
         src_port_q   <= '0;
         opcode_q     <= 16'h0;
         arp_sha_q    <= 48'h0;
         arp_valid_q  <= 1'b0;
         lookup_req_q <= 1'b0;
         runt_count_q <= 16'h0;
`ifdef ARP_SPOOF_CHECK_EN
         spoof_q      <= 1'b0;
`endif
      end else begin
         lookup_req_q <= 1'b0;
         if (beat_s) begin
            case (state_q)
               ST_WORD0: begin
                  dst_sh_q        <= s_axis_tdata[63:16];
                  src_sh_q[47:32] <= s_axis_tdata[15:0];
                  port_sh_q       <= s_axis_tuser[SRC_PORT_POS +: NUM_OUTPUT_QUEUES];
                  if (s_axis_tlast) begin
                     runt_count_q <= sat_inc16(runt_count_q);
                     state_q      <= ST_WORD0;
                  end else begin
                     state_q      <= ST_WORD1;
                  end
               end
               ST_WORD1: begin
                  src_sh_q[31:0] <= s_axis_tdata[63:32];
                  if ((ethertype_s == ETHERTYPE_ARP) && !s_axis_tlast) begin
                     state_q <= ST_WORD2;
                  end else begin
                     // Non-ARP header ends here; an ARP frame ending here is truncated.
                     lookup_req_q <= 1'b1;
                     dst_mac_q    <= dst_sh_q;
                     src_mac_q    <= src_full_s;
                     src_port_q   <= port_sh_q;
                     opcode_q     <= 16'h0;
                     arp_valid_q  <= 1'b0;
`ifdef ARP_SPOOF_CHECK_EN
                     spoof_q      <= 1'b0;
`endif
                     if (ethertype_s == ETHERTYPE_ARP) begin
                        runt_count_q <= sat_inc16(runt_count_q);
                     end else begin
                        runt_count_q <= runt_count_q;
                     end
                     if (s_axis_tlast) begin
                        state_q <= ST_WORD0;
                     end else begin
                        state_q <= ST_WAIT_EOP;
                     end
                  end
               end
               ST_WORD2: begin
                  op_sh_q     <= s_axis_tdata[31:16];
                  sha_hi_sh_q <= s_axis_tdata[15:0];
                  if (s_axis_tlast) begin
                     lookup_req_q <= 1'b1;
                     dst_mac_q    <= dst_sh_q;
                     src_mac_q    <= src_sh_q;
                     src_port_q   <= port_sh_q;
                     opcode_q     <= 16'h0;
                     arp_valid_q  <= 1'b0;
`ifdef ARP_SPOOF_CHECK_EN
                     spoof_q      <= 1'b0;
`endif
                     runt_count_q <= sat_inc16(runt_count_q);
                     state_q      <= ST_WORD0;
                  end else begin
                     state_q      <= ST_WORD3;
                  end
               end
               ST_WORD3: begin
                  lookup_req_q <= 1'b1;
                  dst_mac_q    <= dst_sh_q;
                  src_mac_q    <= src_sh_q;
                  src_port_q   <= port_sh_q;
                  opcode_q     <= op_sh_q;
                  arp_sha_q    <= sha_full_s;
                  arp_valid_q  <= 1'b1;
`ifdef ARP_SPOOF_CHECK_EN
                  spoof_q      <= (sha_full_s != src_sh_q);
`endif
                  if (s_axis_tlast) begin
                     state_q <= ST_WORD0;
                  end else begin
                     state_q <= ST_WAIT_EOP;
                  end
               end
               ST_WAIT_EOP: begin
                  if (s_axis_tlast) begin
                     state_q <= ST_WORD0;
                  end else begin
                     state_q <= ST_WAIT_EOP;
                  end
               end
               default: begin
                  state_q <= ST_WORD0;
               end
            endcase
         end else begin
            state_q <= state_q;
         end
      end
   end

   assign dst_mac    = dst_mac_q;
   assign src_mac    = src_mac_q;
   assign src_port   = src_port_q;
   assign opcode     = opcode_q;
   assign arp_sha    = arp_sha_q;
   assign arp_valid  = arp_valid_q;
   assign lookup_req = lookup_req_q;
   assign runt_count = runt_count_q;
`ifdef ARP_SPOOF_CHECK_EN
   assign spoof_flag = spoof_q;
`endif

endmodule

// File: tb/tb_eth_arp_hdr_parser.sv
// Self-checking bench for eth_arp_hdr_parser: byte-level packet model, random flow control.
module tb_eth_arp_hdr_parser;

   localparam int NQ  = 8;
   localparam int SPP = 16;
   localparam int TUW = 128;

   logic            clk = 1'b0;
   logic            reset;
   logic [63:0]     s_axis_tdata;
   logic [7:0]      s_axis_tkeep;
   logic [TUW-1:0]  s_axis_tuser;
   logic            s_axis_tvalid;
   logic            s_axis_tready;
   logic            s_axis_tlast;
   logic [47:0]     dst_mac;
   logic [47:0]     src_mac;
   logic [NQ-1:0]   src_port;
   logic [15:0]     opcode;
   logic [47:0]     arp_sha;
   logic            arp_valid;
   logic            lookup_req;
   logic [15:0]     runt_count;
`ifdef ARP_SPOOF_CHECK_EN
   logic            spoof_flag;
`endif

   eth_arp_hdr_parser #(
      .NUM_OUTPUT_QUEUES    (NQ),
      .SRC_PORT_POS         (SPP),
      .C_S_AXIS_TUSER_WIDTH (TUW)
   ) dut (
      .clk           (clk),
      .reset         (reset),
      .s_axis_tdata  (s_axis_tdata),
      .s_axis_tkeep  (s_axis_tkeep),
      .s_axis_tuser  (s_axis_tuser),
      .s_axis_tvalid (s_axis_tvalid),
      .s_axis_tready (s_axis_tready),
      .s_axis_tlast  (s_axis_tlast),
      .dst_mac       (dst_mac),
      .src_mac       (src_mac),
      .src_port      (src_port),
      .opcode        (opcode),
      .arp_sha       (arp_sha),
      .arp_valid     (arp_valid),
      .lookup_req    (lookup_req),
`ifdef ARP_SPOOF_CHECK_EN
      .spoof_flag    (spoof_flag),
`endif
      .runt_count    (runt_count)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   logic [7:0]  pkt [0:63];

   // Values the outputs must hold between lookup requests
   logic [47:0] h_dst, h_src, h_sha;
   logic [7:0]  h_port;
   logic [15:0] h_op, h_runt;
   logic        h_av, h_spoof;

   // Effects of the beat accepted on the previous edge, visible on the next check
   logic        pend_req, pend_runt;
   logic [47:0] p_dst, p_src, p_sha;
   logic [7:0]  p_port;
   logic [15:0] p_op;
   logic        p_av, p_spoof;

   task automatic build_pkt(input logic [47:0] dst, input logic [47:0] src, input logic [15:0] et,
                            input logic [15:0] op, input logic [47:0] sha);
      for (int i = 0; i < 64; i++) pkt[i] = 8'($urandom);
      for (int i = 0; i < 6; i++) begin
         pkt[i]      = dst[47-8*i -: 8];
         pkt[6+i]    = src[47-8*i -: 8];
         pkt[22+i]   = sha[47-8*i -: 8];
      end
      pkt[12] = et[15:8];
      pkt[13] = et[7:0];
      pkt[20] = op[15:8];
      pkt[21] = op[7:0];
   endtask

   task automatic apply_reset(input int cycles);
      @(negedge clk);
      reset         = 1'b1;
      s_axis_tvalid = 1'b0;
      repeat (cycles) @(posedge clk);
      @(negedge clk);
      reset     = 1'b0;
      h_dst     = 48'h0; h_src = 48'h0; h_sha = 48'h0; h_port = 8'h0;
      h_op      = 16'h0; h_runt = 16'h0; h_av = 1'b0; h_spoof = 1'b0;
      pend_req  = 1'b0;
      pend_runt = 1'b0;
   endtask

   // Drives nsend beats of an nbeats-long packet from pkt[], then trail idle cycles, checking every cycle
   task automatic drive_pkt(input int nbeats, input int nsend, input logic [7:0] port,
                            input int idle_pct, input bit toggle, input int trail);
      logic [47:0]  e_dst, e_src, e_sha;
      logic [15:0]  e_et, e_op;
      logic         e_av, e_spoof, is_runt, fire;
      logic [63:0]  d;
      logic [127:0] tu;
      int           req_beat, b, idle, cyc;
      e_dst = {pkt[0], pkt[1], pkt[2], pkt[3], pkt[4], pkt[5]};
      e_src = {pkt[6], pkt[7], pkt[8], pkt[9], pkt[10], pkt[11]};
      e_sha = {pkt[22], pkt[23], pkt[24], pkt[25], pkt[26], pkt[27]};
      e_et  = {pkt[12], pkt[13]};
      e_op  = 16'h0;
      e_av  = 1'b0;
      is_runt  = 1'b0;
      req_beat = -1;
      if (nbeats == 1) begin
         is_runt = 1'b1;
      end else if (e_et != 16'h0806) begin
         req_beat = 1;
      end else if (nbeats <= 3) begin
         req_beat = nbeats - 1;
         is_runt  = 1'b1;
      end else begin
         req_beat = 3;
         e_av     = 1'b1;
         e_op     = {pkt[20], pkt[21]};
      end
      e_spoof = e_av && (e_sha != e_src);
      b = 0; idle = 0; cyc = 0;
      while ((b < nsend || idle < trail) && cyc < 2000) begin
         @(negedge clk);
         cyc++;
         if (pend_req) begin
            h_dst = p_dst; h_src = p_src; h_port = p_port; h_op = p_op;
            h_av  = p_av;  h_spoof = p_spoof;
            if (p_av) h_sha = p_sha;
         end
         if (pend_runt) h_runt = (h_runt == 16'hFFFF) ? h_runt : h_runt + 16'd1;
         checks++;
         if (lookup_req !== pend_req) begin
            errors++;
            $display("FAIL lookup_req: got %b expected %b (t=%0t)", lookup_req, pend_req, $time);
         end
         checks++;
         if (dst_mac !== h_dst || src_mac !== h_src) begin
            errors++;
            $display("FAIL macs: got dst %h src %h expected dst %h src %h", dst_mac, src_mac, h_dst, h_src);
         end
         checks++;
         if (src_port !== h_port || opcode !== h_op || arp_valid !== h_av) begin
            errors++;
            $display("FAIL port_op_valid: got %h/%h/%b expected %h/%h/%b",
                     src_port, opcode, arp_valid, h_port, h_op, h_av);
         end
         checks++;
         if (arp_sha !== h_sha) begin
            errors++;
            $display("FAIL arp_sha: got %h expected %h", arp_sha, h_sha);
         end
         checks++;
         if (runt_count !== h_runt) begin
            errors++;
            $display("FAIL runt_count: got %0d expected %0d", runt_count, h_runt);
         end
`ifdef ARP_SPOOF_CHECK_EN
         checks++;
         if (spoof_flag !== h_spoof) begin
            errors++;
            $display("FAIL spoof_flag: got %b expected %b", spoof_flag, h_spoof);
         end
`endif
         pend_req  = 1'b0;
         pend_runt = 1'b0;
         tu = {$urandom, $urandom, $urandom, $urandom};
         d  = {$urandom, $urandom};
         if (b < nsend) begin
            s_axis_tvalid = toggle ? cyc[0] : ($urandom_range(99) >= idle_pct);
            s_axis_tready = toggle ? 1'b1 : ($urandom_range(99) >= idle_pct / 2);
            fire = s_axis_tvalid && s_axis_tready;
            if (fire) begin
               for (int i = 0; i < 8; i++) d[63-8*i -: 8] = pkt[8*b+i];
               if (b == 0) tu[SPP +: NQ] = port;
               if (b == req_beat) begin
                  pend_req = 1'b1;
                  p_dst = e_dst; p_src = e_src; p_port = port; p_op = e_op;
                  p_sha = e_sha; p_av = e_av; p_spoof = e_spoof;
               end
               if (b == nbeats - 1 && is_runt) pend_runt = 1'b1;
               s_axis_tlast = (b == nbeats - 1);
               b++;
            end else begin
               s_axis_tlast = 1'($urandom_range(1));
            end
         end else begin
            s_axis_tvalid = 1'b0;
            s_axis_tready = 1'($urandom_range(1));
            s_axis_tlast  = 1'($urandom_range(1));
            idle++;
         end
         s_axis_tdata = d;
         s_axis_tuser = tu;
         s_axis_tkeep = 8'($urandom);
      end
      if (cyc >= 2000) begin
         checks++;
         errors++;
         $display("FAIL drive_timeout: sent %0d of %0d beats", b, nsend);
      end
   endtask

   task automatic test_reset();
      apply_reset(3);
      checks++;
      if ({dst_mac, src_mac, src_port, opcode, arp_sha, arp_valid, lookup_req, runt_count} !== '0) begin
         errors++;
         $display("FAIL reset_state: outputs not all zero (dst %h runt %0d req %b)", dst_mac, runt_count, lookup_req);
      end
   endtask

   task automatic test_ipv4();
      build_pkt(48'h001122334455, 48'h66778899AABB, 16'h0800, 16'($urandom), {$urandom, 16'($urandom)});
      drive_pkt(8, 8, 8'h04, 0, 1'b0, 2);
      checks++;
      if (src_port !== 8'h04 || opcode !== 16'h0 || arp_valid !== 1'b0) begin
         errors++;
         $display("FAIL ipv4_fields: got port %h op %h valid %b expected 04 0000 0", src_port, opcode, arp_valid);
      end
      checks++;
      if (dst_mac !== 48'h001122334455 || src_mac !== 48'h66778899AABB) begin
         errors++;
         $display("FAIL ipv4_macs: got %h %h", dst_mac, src_mac);
      end
   endtask

   task automatic test_arp_reply();
      build_pkt(48'hFFFFFFFFFFFF, 48'h66778899AABB, 16'h0806, 16'h0002, 48'h66778899AABB);
      drive_pkt(6, 6, 8'h10, 0, 1'b0, 2);
      checks++;
      if (opcode !== 16'h0002 || arp_valid !== 1'b1 || arp_sha !== 48'h66778899AABB) begin
         errors++;
         $display("FAIL arp_reply: got op %h valid %b sha %h", opcode, arp_valid, arp_sha);
      end
`ifdef ARP_SPOOF_CHECK_EN
      checks++;
      if (spoof_flag !== 1'b0) begin
         errors++;
         $display("FAIL arp_reply_spoof: got %b expected 0", spoof_flag);
      end
`endif
   endtask

   task automatic test_arp_spoof();
      build_pkt(48'h0A0B0C0D0E0F, 48'h66778899AABB, 16'h0806, 16'h0002, 48'hDEADBEEF0001);
      drive_pkt(5, 5, 8'h02, 20, 1'b0, 2);
      checks++;
      if (arp_sha !== 48'hDEADBEEF0001 || arp_valid !== 1'b1) begin
         errors++;
         $display("FAIL arp_spoof_sha: got %h valid %b", arp_sha, arp_valid);
      end
`ifdef ARP_SPOOF_CHECK_EN
      checks++;
      if (spoof_flag !== 1'b1) begin
         errors++;
         $display("FAIL arp_spoof_flag: got %b expected 1", spoof_flag);
      end
`endif
   endtask

   task automatic test_runt();
      build_pkt(48'h111111111111, 48'h222222222222, 16'h0800, 16'h0, 48'h0);
      drive_pkt(1, 1, 8'h01, 0, 1'b0, 0);
      build_pkt(48'h333333333333, 48'h444444444444, 16'h86DD, 16'h0, 48'h0);
      drive_pkt(3, 3, 8'h20, 0, 1'b0, 2);
      checks++;
      if (runt_count !== 16'd1 || dst_mac !== 48'h333333333333) begin
         errors++;
         $display("FAIL runt_single: got runt %0d dst %h expected 1 333333333333", runt_count, dst_mac);
      end
   endtask

   task automatic test_toggle_reset();
      build_pkt(48'h5A5A5A5A5A5A, 48'hA5A5A5A5A5A5, 16'h0806, 16'h0001, 48'h123456789ABC);
      drive_pkt(6, 2, 8'h40, 0, 1'b1, 3);
      apply_reset(2);
      checks++;
      if ({dst_mac, src_mac, src_port, opcode, arp_sha, arp_valid, lookup_req, runt_count} !== '0) begin
         errors++;
         $display("FAIL reset_midpkt: outputs not zero (dst %h op %h runt %0d)", dst_mac, opcode, runt_count);
      end
      build_pkt(48'h0102030405FF, 48'h0607080900AA, 16'h0806, 16'h0001, 48'hCAFEF00D1234);
      drive_pkt(4, 4, 8'h80, 30, 1'b0, 2);
      checks++;
      if (opcode !== 16'h0001 || arp_sha !== 48'hCAFEF00D1234 || src_port !== 8'h80) begin
         errors++;
         $display("FAIL after_reset_parse: got op %h sha %h port %h", opcode, arp_sha, src_port);
      end
   endtask

   task automatic test_back_to_back();
      logic [47:0] dst;
      dst = 48'h0;
      for (int k = 0; k < 6; k++) begin
         dst = {$urandom, 16'($urandom)};
         build_pkt(dst, {$urandom, 16'($urandom)}, 16'h0800, 16'h0, 48'h0);
         drive_pkt(2, 2, 8'(1 << (k % 8)), 0, 1'b0, (k == 5) ? 2 : 0);
      end
      checks++;
      if (dst_mac !== dst) begin
         errors++;
         $display("FAIL b2b_last_dst: got %h expected %h", dst_mac, dst);
      end
   endtask

   task automatic test_random();
      logic [47:0] src;
      logic [15:0] et;
      int          nb;
      bit          is_arp;
      for (int k = 0; k < 40; k++) begin
         is_arp = 1'($urandom_range(1));
         nb     = $urandom_range(8, 1);
         if (is_arp && nb == 2) nb = 3;
         et = 16'($urandom);
         if (et == 16'h0806) et = 16'h0800;
         if (is_arp) et = 16'h0806;
         src = {$urandom, 16'($urandom)};
         build_pkt({$urandom, 16'($urandom)}, src, et, 16'($urandom_range(2, 1)),
                   $urandom_range(1) ? src : {$urandom, 16'($urandom)});
         drive_pkt(nb, nb, 8'($urandom), $urandom_range(60, 0), 1'b0, (k == 39) ? 2 : $urandom_range(2, 0));
      end
   endtask

   task automatic test_runt_saturation();
      int need;
      need = 65535 - int'(h_runt) + 3;
      build_pkt(48'h0, 48'h0, 16'h0800, 16'h0, 48'h0);
      for (int k = 0; k < need; k++) begin
         drive_pkt(1, 1, 8'h01, 0, 1'b0, (k == need - 1) ? 2 : 0);
      end
      checks++;
      if (runt_count !== 16'hFFFF) begin
         errors++;
         $display("FAIL runt_saturation: got %h expected ffff", runt_count);
      end
   endtask

   initial begin
      reset         = 1'b1;
      s_axis_tdata  = 64'h0;
      s_axis_tkeep  = 8'h0;
      s_axis_tuser  = '0;
      s_axis_tvalid = 1'b0;
      s_axis_tready = 1'b0;
      s_axis_tlast  = 1'b0;
      test_reset();
      test_ipv4();
      test_arp_reply();
      test_arp_spoof();
      test_runt();
      test_toggle_reset();
      test_back_to_back();
      test_random();
      test_runt_saturation();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
